// File: rtl/can_mac_rx_destuffer_param_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
//   Shared types and helpers for the CAN MAC RX destuffer slice.
//   - ds_mode_e : destuffing mode selected per sampled bit
//   - RECESSIVE : bus idle / reset value of the last-seen bit
//   - cnt_width / ptr_width : width helpers for counters and FIFO pointers
// ---------------------------------------------------------------------------
package can_pkg;

  typedef enum logic [1:0] {
    DS_OFF,
    DS_DYNAMIC,
    DS_FIXED
  } ds_mode_e;

  localparam logic RECESSIVE = 1'b1;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to address depth entries (without the wrap bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/can_mac_rx_destuffer_param_fifo.sv
// ---------------------------------------------------------------------------
// can_bit_fifo
//   First-word-fall-through single-bit FIFO. o_dout always shows the head
//   entry straight from storage, so a pushed bit is visible the edge after
//   the push. Pointers carry one extra wrap bit to tell full from empty.
//   Ports:
//     clk, reset   : clock, async active-high reset
//     i_flush      : synchronous clear, wins over push/pop
//     i_push, i_din: write request and data (accepted when not full, or
//                    when a pop happens in the same cycle)
//     i_pop        : read request (ignored when empty)
//     o_dout       : head entry
//     o_full/o_empty : occupancy flags
// ---------------------------------------------------------------------------
module can_bit_fifo
  import can_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];

  assign w_do_pop  = i_pop && !o_empty;
  // When full, the write lands in the slot the same-cycle pop vacates.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_mac_rx_destuffer_param.sv
// ---------------------------------------------------------------------------
// can_mac_rx_destuffer_param
//   Removes CAN stuff bits between the RX bit sampler and the MAC frame FSM.
//   Dynamic mode drops the complementary bit after STUFF_LEN identical bits;
//   fixed mode (FD CRC) drops one bit every FIXED_PERIOD+1 bits, starting
//   with the first bit of the field. Kept bits are buffered in a small FWFT
//   FIFO with a valid/ready handshake. Any stuff violation locks the
//   destuffer until restart/reset.
//   Ports:
//     clk, reset         : clock, async active-high reset
//     can_clk_en         : bit-time strobe, bit_in sampled when high
//     bit_in             : stuffed bit
//     destuffing_enable  : stuff removal active (SOF..CRC)
//     fixed_stuff_en     : fixed-stuff mode (needs destuffing_enable)
//     restart            : synchronous clear of all state and the FIFO
//     bit_out, valid     : FIFO head and non-empty flag
//     ready              : consumer accepts bit_out this cycle
//     stuff_error        : one-cycle pulse on a stuff violation
//     err_locked         : sticky error, pushes suppressed
//     overflow           : one-cycle pulse when a kept bit is lost
//     stuff_count        : dynamic stuff bits removed, wraps
// ---------------------------------------------------------------------------
module can_mac_rx_destuffer_param
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = 5,
  parameter int unsigned FIXED_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             can_clk_en,
  input  logic             bit_in,
  input  logic             destuffing_enable,
  input  logic             fixed_stuff_en,
  input  logic             restart,
  output logic             bit_out,
  output logic             valid,
  input  logic             ready,
  output logic             stuff_error,
  output logic             err_locked,
  output logic             overflow,
  output logic [CNT_W-1:0] stuff_count
);

  localparam int unsigned RW = cnt_width(STUFF_LEN);
  localparam int unsigned FW = cnt_width(FIXED_PERIOD);
  localparam logic [RW-1:0] RUN_MAX = RW'(STUFF_LEN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [FW-1:0] FIX_MAX = FW'(FIXED_PERIOD);

  logic [RW-1:0]    r_run_len;
  logic             r_last_bit;
  logic [FW-1:0]    r_fix_cnt;
  logic             r_fix_active;
  logic             r_err_locked;
  logic             r_stuff_err;
  logic             r_overflow;
  logic [CNT_W-1:0] r_stuff_cnt;

  ds_mode_e         w_mode;
  logic             w_same;
  logic [RW-1:0]    w_run_track;
  logic [RW-1:0]    w_run_nxt;
  logic             w_last_nxt;
  logic [FW-1:0]    w_fix_cnt_nxt;
  logic             w_fix_active_nxt;
  logic             w_push;
  logic             w_err;
  logic             w_cnt_inc;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf;

  assign valid       = !w_empty;
  assign w_pop       = !w_empty && ready;
  assign w_ovf       = w_push && w_full && !w_pop;
  assign stuff_error = r_stuff_err;
  assign err_locked  = r_err_locked;
  assign overflow    = r_overflow;
  assign stuff_count = r_stuff_cnt;

  always_comb begin
    w_mode = DS_OFF;
    if (destuffing_enable) begin
      w_mode = fixed_stuff_en ? DS_FIXED : DS_DYNAMIC;
    end

    w_same      = (bit_in == r_last_bit);
    w_run_track = RUN_ONE;
    if (w_same) begin
      w_run_track = (r_run_len == RUN_MAX) ? r_run_len : r_run_len + RUN_ONE;
    end

    w_run_nxt        = r_run_len;
    w_last_nxt       = r_last_bit;
    w_fix_cnt_nxt    = r_fix_cnt;
    w_fix_active_nxt = r_fix_active;
    w_push           = 1'b0;
    w_err            = 1'b0;
    w_cnt_inc        = 1'b0;

    if (can_clk_en) begin
      w_run_nxt        = w_run_track;
      w_last_nxt       = bit_in;
      // Tracks the mode of the previous sampled bit so the first bit of a
      // fixed-stuff field is recognised as a stuff bit.
      w_fix_active_nxt = (w_mode == DS_FIXED);
      if (!r_err_locked) begin
        unique case (w_mode)
          DS_OFF: begin
            w_push = 1'b1;
          end
          DS_DYNAMIC: begin
            if (r_run_len == RUN_MAX) begin
              if (w_same) w_err = 1'b1;
              else        w_cnt_inc = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end
          DS_FIXED: begin
            if (!r_fix_active || (r_fix_cnt == FIX_MAX)) begin
              w_fix_cnt_nxt = '0;
              w_run_nxt     = RUN_ONE;
              if (w_same) w_err = 1'b1;
            end else begin
              w_push        = 1'b1;
              w_fix_cnt_nxt = r_fix_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_len    <= '0;
      r_last_bit   <= RECESSIVE;
      r_fix_cnt    <= '0;
      r_fix_active <= 1'b0;
      r_err_locked <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_stuff_cnt  <= '0;
    end else if (restart) begin
      r_run_len    <= '0;
      r_last_bit   <= RECESSIVE;
      r_fix_cnt    <= '0;
      r_fix_active <= 1'b0;
      r_err_locked <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_stuff_cnt  <= '0;
    end else begin
      r_run_len    <= w_run_nxt;
      r_last_bit   <= w_last_nxt;
      r_fix_cnt    <= w_fix_cnt_nxt;
      r_fix_active <= w_fix_active_nxt;
      r_err_locked <= r_err_locked | w_err;
      r_stuff_err  <= w_err;
      r_overflow   <= w_ovf;
      r_stuff_cnt  <= r_stuff_cnt + CNT_W'(w_cnt_inc);
    end
  end

  can_bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (restart),
    .i_push  (w_push),
    .i_din   (bit_in),
    .i_pop   (w_pop),
    .o_dout  (bit_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_can_mac_rx_destuffer_param.sv
module tb_can_mac_rx_destuffer_param;

  localparam int unsigned SL    = 5;
  localparam int unsigned FP    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          can_clk_en;
  logic          bit_in;
  logic          destuffing_enable;
  logic          fixed_stuff_en;
  logic          restart;
  logic          bit_out;
  logic          valid;
  logic          ready;
  logic          stuff_error;
  logic          err_locked;
  logic          overflow;
  logic [CW-1:0] stuff_count;

  int n_total = 0;
  int n_bad   = 0;

  can_mac_rx_destuffer_param #(
    .STUFF_LEN    (SL),
    .FIXED_PERIOD (FP),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .can_clk_en        (can_clk_en),
    .bit_in            (bit_in),
    .destuffing_enable (destuffing_enable),
    .fixed_stuff_en    (fixed_stuff_en),
    .restart           (restart),
    .bit_out           (bit_out),
    .valid             (valid),
    .ready             (ready),
    .stuff_error       (stuff_error),
    .err_locked        (err_locked),
    .overflow          (overflow),
    .stuff_count       (stuff_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: history of sampled bits, position inside the fixed
  // field, and a bounded queue standing in for the output buffer.
  bit hist[$];
  bit q[$];
  int fseg;
  int m_cnt;
  bit m_locked;
  bit m_err;
  bit m_ovf;

  task automatic model_clear();
    hist.delete();
    q.delete();
    fseg     = -1;
    m_cnt    = 0;
    m_locked = 0;
    m_err    = 0;
    m_ovf    = 0;
  endtask

  function automatic bit model_last();
    return (hist.size() == 0) ? 1'b1 : hist[hist.size()-1];
  endfunction

  // True when the last SL sampled bits are all identical.
  function automatic bit run_full();
    if (hist.size() < SL) return 1'b0;
    for (int i = hist.size() - SL; i < hist.size(); i++)
      if (hist[i] != hist[hist.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit pop, push, b, last, fixed;
    int k;
    m_err = 0;
    m_ovf = 0;
    push  = 0;
    b     = bit_in;
    if (restart) begin
      model_clear();
      return;
    end
    pop = (q.size() != 0) && ready;
    if (can_clk_en) begin
      last  = model_last();
      fixed = destuffing_enable && fixed_stuff_en;
      k     = (fseg >= 0) ? fseg + 1 : 0;
      fseg  = fixed ? k : -1;
      if (!m_locked) begin
        if (!destuffing_enable) push = 1;
        else if (fixed) begin
          if (k % (FP + 1) == 0) begin
            if (b == last) m_err = 1;
          end else push = 1;
        end else if (run_full()) begin
          if (b == last) m_err = 1;
          else m_cnt = (m_cnt + 1) % (1 << CW);
        end else push = 1;
      end
      hist.push_back(b);
      if (hist.size() > SL) void'(hist.pop_front());
      if (m_err) m_locked = 1;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("valid", valid, q.size() != 0);
    if (q.size() != 0) check("bit_out", bit_out, q[0]);
    check("stuff_error", stuff_error, m_err);
    check("overflow", overflow, m_ovf);
    check("err_locked", err_locked, m_locked);
    check("stuff_count", stuff_count, m_cnt);
  endtask

  task automatic send(input bit b, input bit de, input bit fx, input bit rdy);
    can_clk_en        = 1;
    bit_in            = b;
    destuffing_enable = de;
    fixed_stuff_en    = fx;
    ready             = rdy;
    restart           = 0;
    step();
  endtask

  task automatic do_restart();
    can_clk_en = 0;
    restart    = 1;
    step();
    restart    = 0;
  endtask

  initial begin
    int drained;
    bit b;
    bit pat[6];
    reset = 1; can_clk_en = 0; bit_in = 0; destuffing_enable = 0;
    fixed_stuff_en = 0; restart = 0; ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bit_out", bit_out, 0);
    check("rst_valid", valid, 0);
    check("rst_stuff_error", stuff_error, 0);
    check("rst_err_locked", err_locked, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stuff_count", stuff_count, 0);
    reset = 0;

    // Five dominant bits, complementary stuff bit, then data.
    foreach (pat[i]) pat[i] = (i == 5);
    for (int i = 0; i < 6; i++) send(pat[i], 1, 0, 1);
    send(0, 1, 0, 1);
    check("plan1_count", stuff_count, 1);
    check("plan1_locked", err_locked, 0);

    // Six recessive bits: the sixth violates the stuff rule.
    do_restart();
    for (int i = 0; i < 5; i++) send(1, 1, 0, 1);
    send(1, 1, 0, 1);
    check("plan2_err_pulse", stuff_error, 1);
    check("plan2_locked", err_locked, 1);
    send(0, 1, 0, 1);
    check("plan2_pulse_one_cycle", stuff_error, 0);
    do_restart();
    check("plan2_restart_locked", err_locked, 0);
    check("plan2_restart_count", stuff_count, 0);

    // Fixed-stuff field: stuff, 4 data, stuff, 4 data, bad stuff.
    send(1, 1, 0, 1);
    foreach (pat[i]) pat[i] = (i == 1) || (i == 3) || (i == 4);
    for (int i = 0; i < 6; i++) send(pat[i], 1, 1, 1);
    for (int i = 0; i < 4; i++) send(1, 1, 1, 1);
    send(1, 1, 1, 1);
    check("plan3_fixed_err", stuff_error, 1);

    // Buffer fill without ready, overflow, then drain.
    do_restart();
    foreach (pat[i]) pat[i] = (i == 0) || (i == 2) || (i == 3);
    for (int i = 0; i < 5; i++) send(pat[i], 0, 0, 0);
    check("plan4_overflow", overflow, 1);
    can_clk_en = 0;
    ready = 1;
    for (int i = 0; i < 4; i++) step();
    check("plan4_drained", valid, 0);

    // Full buffer with simultaneous pop and push, then count what drains.
    for (int i = 0; i < 4; i++) send(i[0], 0, 0, 0);
    send(1, 0, 0, 1);
    check("plan5_no_overflow", overflow, 0);
    can_clk_en = 0;
    ready = 1;
    drained = 0;
    for (int i = 0; i < 10 && valid; i++) begin
      drained++;
      step();
    end
    check("plan5_occupancy", drained, 4);

    // Nine stuff bits wrap the 3-bit counter to 1.
    do_restart();
    for (int i = 0; i < 50; i++) begin
      b = run_full() ? ~model_last() : model_last();
      send(b, 1, 0, 1);
    end
    check("plan6_wrap_count", stuff_count, 1);

    // Asynchronous reset mid-frame with data buffered.
    for (int i = 0; i < 3; i++) send(0, 0, 0, 0);
    #2 reset = 1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_bit_out", bit_out, 0);
    check("arst_count", stuff_count, 0);
    check("arst_locked", err_locked, 0);
    check("arst_err", stuff_error, 0);
    check("arst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();

    // Randomised traffic, mostly stuff-rule compliant.
    for (int n = 0; n < 1500; n++) begin
      restart    = ($urandom_range(0, 59) == 0);
      can_clk_en = ($urandom_range(0, 3) != 0);
      ready      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) destuffing_enable = ~destuffing_enable;
      if ($urandom_range(0, 19) == 0) fixed_stuff_en = ~fixed_stuff_en;
      b = ($urandom_range(0, 3) == 0) ? ~model_last() : model_last();
      if (run_full() && $urandom_range(0, 15) != 0) b = ~model_last();
      bit_in = b;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
